// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide beside the execute-stage ALU.
// Owns the HI/LO pair. Multiply uses one shift-add step per cycle and divide
// uses one restoring-subtract step per cycle. Signed ops run on magnitudes
// and are sign-corrected in FIX.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] src_a_i,
  input  logic [WIDTH-1:0] src_b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_by_zero_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t state_q, state_d;

  logic [CW-1:0]      cnt_q;
  logic               is_div_q;   // current op is div/divu
  logic               neg_q;      // product / quotient must be negated
  logic               neg_rem_q;  // remainder takes the dividend's sign
  logic               zero_q;     // divisor was zero
  logic [WIDTH-1:0]   opnd_q;     // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   orig_a_q;   // dividend as given, for the divide-by-zero result
  logic [2*WIDTH-1:0] prod_q;     // multiply accumulator, multiplier shifts out at the LSB
  logic [WIDTH-1:0]   rem_q;      // partial remainder
  logic [WIDTH-1:0]   quo_q;      // dividend shifts out at the MSB, quotient shifts in at the LSB
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q, dbz_q;

  logic               arith_start, mt_start;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh, rem_diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign arith_start = start_i && !op_i[2];
  assign mt_start    = start_i && op_i[2] && !op_i[1];

  // Operand magnitudes, one step of each algorithm, and the final sign fix-up
  always_comb begin
    a_neg    = op_i[0] & src_a_i[WIDTH-1];
    b_neg    = op_i[0] & src_b_i[WIDTH-1];
    a_abs    = a_neg ? -src_a_i : src_a_i;
    b_abs    = b_neg ? -src_b_i : src_b_i;
    mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
    // The trial remainder is WIDTH+1 bits; its top bit after the subtract is the borrow
    rem_sh   = {rem_q, quo_q[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, opnd_q};
    prod_fix = neg_q ? -prod_q : prod_q;
    quo_fix  = neg_q ? -quo_q : quo_q;
    rem_fix  = neg_rem_q ? -rem_q : rem_q;
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state: accept in IDLE, run WIDTH steps, one fix-up cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (arith_start) state_d = S_CALC;
      S_CALC:  if (cnt_q == LAST) state_d = S_FIX;
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy_o        = (state_q != S_IDLE);
    done_o        = done_q;
    div_by_zero_o = dbz_q;
    hi_o          = hi_q;
    lo_o          = lo_q;
  end

  // Datapath: operand latch, iteration, HI/LO write-back
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      zero_q    <= 1'b0;
      opnd_q    <= '0;
      orig_a_q  <= '0;
      prod_q    <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (arith_start) begin
            is_div_q  <= op_i[1];
            neg_q     <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            zero_q    <= op_i[1] && (src_b_i == '0);
            orig_a_q  <= src_a_i;
            cnt_q     <= '0;
            dbz_q     <= 1'b0;
            if (op_i[1]) begin
              opnd_q <= b_abs;
              quo_q  <= a_abs;
              rem_q  <= '0;
            end else begin
              opnd_q <= a_abs;
              prod_q <= {{WIDTH{1'b0}}, b_abs};
            end
          end else if (mt_start) begin
            if (op_i[0]) lo_q <= src_a_i;
            else         hi_q <= src_a_i;
          end
        end
        S_CALC: begin
          cnt_q <= cnt_q + 1'b1;
          if (is_div_q) begin
            // Restoring step: keep the subtraction only if it did not borrow
            if (!rem_diff[WIDTH]) begin
              rem_q <= rem_diff[WIDTH-1:0];
              quo_q <= {quo_q[WIDTH-2:0], 1'b1};
            end else begin
              rem_q <= rem_sh[WIDTH-1:0];
              quo_q <= {quo_q[WIDTH-2:0], 1'b0};
            end
          end else begin
            prod_q <= {mul_sum, prod_q[WIDTH-1:1]};
          end
        end
        S_FIX: begin
          done_q <= 1'b1;
          dbz_q  <= zero_q;
          if (zero_q) begin
            hi_q <= orig_a_q;
            lo_q <= '1;
          end else if (is_div_q) begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end else begin
            {hi_q, lo_q} <= prod_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: a 32-bit and an 8-bit instance,
// directed tables, corner sequences and random ops against an arithmetic model.
module tb_muldiv_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start;
  logic [2:0]  op;
  logic [31:0] a, b;
  int          cur;   // 0 selects the 32-bit instance, 1 the 8-bit one
  int          w;

  logic        s32, s8;
  logic        busy32, done32, dbz32, busy8, done8, dbz8;
  logic [31:0] hi32, lo32;
  logic [7:0]  hi8, lo8;

  assign s32 = start && (cur == 0);
  assign s8  = start && (cur == 1);

  muldiv_unit #(.WIDTH(32)) u32 (
    .clk_i(clk), .reset_i(rst), .start_i(s32), .op_i(op), .src_a_i(a), .src_b_i(b),
    .busy_o(busy32), .done_o(done32), .div_by_zero_o(dbz32), .hi_o(hi32), .lo_o(lo32));

  muldiv_unit #(.WIDTH(8)) u8 (
    .clk_i(clk), .reset_i(rst), .start_i(s8), .op_i(op), .src_a_i(a[7:0]), .src_b_i(b[7:0]),
    .busy_o(busy8), .done_o(done8), .div_by_zero_o(dbz8), .hi_o(hi8), .lo_o(lo8));

  logic        busy_v, done_v, dbz_v;
  logic [31:0] hi_v, lo_v;
  always_comb begin
    busy_v = (cur == 1) ? busy8 : busy32;
    done_v = (cur == 1) ? done8 : done32;
    dbz_v  = (cur == 1) ? dbz8  : dbz32;
    hi_v   = (cur == 1) ? {24'b0, hi8} : hi32;
    lo_v   = (cur == 1) ? {24'b0, lo8} : lo32;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic longint sx(input logic [63:0] v, input int wd);
    if (v[wd-1]) return longint'(v) - (longint'(1) << wd);
    return longint'(v);
  endfunction

  // Reference: plain arithmetic on wide integers, then split into HI/LO
  function automatic void model(input int wd, input logic [2:0] o, input logic [31:0] xi,
                                input logic [31:0] yi, output logic [31:0] eh,
                                output logic [31:0] el, output logic ed);
    logic [63:0] m, x, y, p;
    longint sa, sb, q, r;
    m  = (64'd1 << wd) - 64'd1;
    x  = {32'b0, xi} & m;
    y  = {32'b0, yi} & m;
    sa = sx(x, wd);
    sb = sx(y, wd);
    ed = 1'b0;
    case (o)
      3'd0: p = x * y;
      3'd1: p = 64'(sa * sb);
      default: begin
        if (y == 0) begin
          ed = 1'b1;
          p  = (x << wd) | m;
        end else if (o == 3'd2) begin
          p = ((x % y) << wd) | (x / y);
        end else begin
          q = sa / sb;
          r = sa % sb;
          p = ((64'(r) & m) << wd) | (64'(q) & m);
        end
      end
    endcase
    eh = 32'((p >> wd) & m);
    el = 32'(p & m);
  endfunction

  // Issue an arithmetic op at the current negedge and wait for done.
  // poke >= 0 pulses start with op=mthi that many cycles after acceptance.
  task automatic run_arith(input string nm, input logic [2:0] o, input logic [31:0] x,
                           input logic [31:0] y, input logic [31:0] ehi,
                           input logic [31:0] elo, input logic edbz, input int poke);
    int lat, busy_cnt;
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; lat = 0; busy_cnt = 0;
    chk({nm, " busy_after_start"}, 64'(busy_v), 64'd1);
    chk({nm, " dbz_cleared"}, 64'(dbz_v), 64'd0);
    while (!done_v && lat < 200) begin
      if (busy_v) busy_cnt++;
      start = (lat == poke);
      if (lat == poke) begin op = 3'b100; a = 32'hDEAD_BEEF; end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    chk({nm, " latency"}, 64'(lat), 64'(w + 1));
    chk({nm, " busy_cycles"}, 64'(busy_cnt), 64'(w + 1));
    chk({nm, " busy_at_done"}, 64'(busy_v), 64'd0);
    chk({nm, " hi"}, 64'(hi_v), 64'(ehi));
    chk({nm, " lo"}, 64'(lo_v), 64'(elo));
    chk({nm, " dbz"}, 64'(dbz_v), 64'(edbz));
  endtask

  task automatic check_reset_state(input string nm);
    chk({nm, " busy"}, 64'(busy_v), 64'd0);
    chk({nm, " done"}, 64'(done_v), 64'd0);
    chk({nm, " dbz"},  64'(dbz_v),  64'd0);
    chk({nm, " hi"},   64'(hi_v),   64'd0);
    chk({nm, " lo"},   64'(lo_v),   64'd0);
  endtask

  task automatic run_random(input int n);
    logic [2:0]  o;
    logic [31:0] x, y, eh, el;
    logic        ed;
    for (int i = 0; i < n; i++) begin
      o = 3'($urandom_range(0, 3));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 7))
        0: y = 32'h0;
        1: y = 32'hFFFF_FFFF;
        2: y = 32'h1;
        3: x = 32'h8000_0000 >> (32 - w);
        default: ;
      endcase
      if (w < 32) begin
        x = x & ((32'd1 << w) - 32'd1);
        y = y & ((32'd1 << w) - 32'd1);
      end
      model(w, o, x, y, eh, el, ed);
      run_arith($sformatf("rnd%0d_op%0d", i, o), o, x, y, eh, el, ed, -1);
    end
  endtask

  typedef struct {
    string       nm;
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        dbz;
  } vec_t;

  vec_t t32[8];
  vec_t t8[5];

  initial begin
    bit seen_done;

    t32[0] = '{"multu_max",   3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    t32[1] = '{"mult_m3x5",   3'd1, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
    t32[2] = '{"div_m7d2",    3'd3, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    t32[3] = '{"divu_by0",    3'd2, 32'h0000_0093, 32'd0,         32'h0000_0093, 32'hFFFF_FFFF, 1'b1};
    t32[4] = '{"divu_ae_93",  3'd2, 32'h0000_00AE, 32'h93,        32'h0000_001B, 32'h0000_0001, 1'b0};
    t32[5] = '{"div_min_m1",  3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    t32[6] = '{"div_7_m2",    3'd3, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
    t32[7] = '{"div_m8_by0",  3'd3, 32'hFFFF_FFF8, 32'd0,         32'hFFFF_FFF8, 32'hFFFF_FFFF, 1'b1};

    t8[0] = '{"w8_multu_max", 3'd0, 32'hFF, 32'hFF, 32'hFE, 32'h01, 1'b0};
    t8[1] = '{"w8_mult_m3x5", 3'd1, 32'hFD, 32'h05, 32'hFF, 32'hF1, 1'b0};
    t8[2] = '{"w8_div_m7d2",  3'd3, 32'hF9, 32'h02, 32'hFF, 32'hFD, 1'b0};
    t8[3] = '{"w8_div_min",   3'd3, 32'h80, 32'hFF, 32'h00, 32'h80, 1'b0};
    t8[4] = '{"w8_divu_by0",  3'd2, 32'h93, 32'h00, 32'h93, 32'hFF, 1'b1};

    // ---------------- WIDTH = 32 ----------------
    cur = 0; w = 32;
    rst = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_reset_state("w32_reset");

    // Table ops run back to back: each start lands in the previous done cycle
    foreach (t32[i])
      run_arith(t32[i].nm, t32[i].op, t32[i].a, t32[i].b, t32[i].hi, t32[i].lo, t32[i].dbz, -1);

    // mtlo / mthi from IDLE; div_by_zero from the last op must hold
    start = 1'b1; op = 3'b101; a = 32'h0000_1234;
    @(negedge clk);
    start = 1'b0;
    chk("mtlo lo", 64'(lo_v), 64'h1234);
    chk("mtlo hi_kept", 64'(hi_v), 64'hFFFF_FFF8);
    chk("mtlo busy", 64'(busy_v), 64'd0);
    chk("mtlo done", 64'(done_v), 64'd0);
    chk("mtlo dbz_held", 64'(dbz_v), 64'd1);
    start = 1'b1; op = 3'b100; a = 32'h0000_5678;
    @(negedge clk);
    start = 1'b0;
    chk("mthi hi", 64'(hi_v), 64'h5678);
    chk("mthi lo_kept", 64'(lo_v), 64'h1234);

    // Reserved op is ignored
    start = 1'b1; op = 3'b110; a = 32'hFFFF_0000;
    @(negedge clk);
    start = 1'b0;
    chk("rsvd busy", 64'(busy_v), 64'd0);
    chk("rsvd hi", 64'(hi_v), 64'h5678);

    // mthi pulsed while busy must be ignored
    run_arith("multu_7x6_poke", 3'd0, 32'd7, 32'd6, 32'd0, 32'd42, 1'b0, 5);
    @(negedge clk);
    chk("done_one_cycle", 64'(done_v), 64'd0);
    start = 1'b1; op = 3'b101; a = 32'h0000_1234;
    @(negedge clk);
    start = 1'b0;
    chk("mtlo2 lo", 64'(lo_v), 64'h1234);
    chk("mtlo2 busy", 64'(busy_v), 64'd0);
    chk("mtlo2 done", 64'(done_v), 64'd0);

    // Reset mid-divide: results discarded, no done
    start = 1'b1; op = 3'b010; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_state("midop_reset");
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_v || busy_v) seen_done = 1'b1;
    end
    chk("midop_reset quiet", 64'(seen_done), 64'd0);

    run_random(60);

    // ---------------- WIDTH = 8 ----------------
    @(negedge clk);
    cur = 1; w = 8;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_state("w8_reset");
    foreach (t8[i])
      run_arith(t8[i].nm, t8[i].op, t8[i].a, t8[i].b, t8[i].hi, t8[i].lo, t8[i].dbz, -1);
    run_random(60);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
